// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate decode stage: classifies the instruction format,
// sign/zero-extends the immediate and buffers results behind a 2-entry skid.
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter int RV64_OPS = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit HAS_OPIMM32 = (RV64_OPS != 0) && (XLEN == 64);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // ---------------- decode ----------------
    logic [6:0]      w_opcode;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_z;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    entry_t          w_dec;

    // Each form keeps instr[31] as the top payload bit so the replication count stays >= 1.
    assign w_opcode = in_instr[6:0];
    assign w_imm_i  = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
    assign w_imm_s  = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
    assign w_imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign w_imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_z  = {{(XLEN-5){1'b0}}, in_instr[19:15]};

    always_comb begin
        w_imm     = '0;
        w_fmt     = FMT_R;
        w_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR: begin
                    w_fmt = FMT_I;
                    w_imm = w_imm_i;
                end
                OPC_STORE: begin
                    w_fmt = FMT_S;
                    w_imm = w_imm_s;
                end
                OPC_BRANCH: begin
                    w_fmt = FMT_B;
                    w_imm = w_imm_b;
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_fmt = FMT_U;
                    w_imm = w_imm_u;
                end
                OPC_JAL: begin
                    w_fmt = FMT_J;
                    w_imm = w_imm_j;
                end
                OPC_SYSTEM: begin
                    if (in_instr[14]) begin
                        w_fmt = FMT_Z;
                        w_imm = w_imm_z;
                    end else begin
                        w_fmt = FMT_I;
                        w_imm = w_imm_i;
                    end
                end
                OPC_OP: begin
                    w_fmt = FMT_R;
                end
                OPC_OPIMM32: begin
                    if (HAS_OPIMM32) begin
                        w_fmt = FMT_I;
                        w_imm = w_imm_i;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign w_dec = '{instr: in_instr, pc: in_pc, imm: w_imm, fmt: w_fmt, illegal: w_illegal};

    // ---------------- occupancy control ----------------
    state_t r_state;
    state_t w_state_nxt;
    logic   r_in_ready;
    logic   r_out_valid;
    logic   w_accept;
    logic   w_emit;
    logic   w_ld_main;
    logic   w_ld_skid;
    logic   w_mv_skid;
    entry_t r_main;
    entry_t r_skid;

    assign w_accept = in_valid && r_in_ready;
    assign w_emit   = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_FULL);
            r_out_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    // Flush drops any same-cycle accept; a same-cycle emit still completes downstream.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_main   = 1'b0;
        w_ld_skid   = 1'b0;
        w_mv_skid   = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = S_ONE;
                        w_ld_main   = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_emit) begin
                        w_ld_main = 1'b1;
                    end else if (w_emit) begin
                        w_state_nxt = S_EMPTY;
                    end else if (w_accept) begin
                        w_state_nxt = S_FULL;
                        w_ld_skid   = 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_emit) begin
                        w_state_nxt = S_ONE;
                        w_mv_skid   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main <= '0;
        end else if (w_ld_main) begin
            r_main <= w_dec;
        end else if (w_mv_skid) begin
            r_main <= r_skid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_ld_skid) begin
            r_skid <= w_dec;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_main.instr;
    assign out_pc      = r_main.pc;
    assign out_imm     = r_main.imm;
    assign out_fmt     = r_main.fmt;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: three configurations share one stimulus stream and are
// checked against an arithmetic decode model and a FIFO occupancy model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    always #5 clk = ~clk;

    logic        a_ir, a_ov, a_ill, b_ir, b_ov, b_ill, c_ir, c_ov, c_ill;
    logic [31:0] a_ins, b_ins, c_ins, a_pc, a_imm;
    logic [63:0] b_pc, b_imm, c_pc, c_imm;
    logic [2:0]  a_fmt, b_fmt, c_fmt;

    imm_decode_stage #(.XLEN(32), .RV64_OPS(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_ov), .out_ready(out_ready),
        .out_instr(a_ins), .out_pc(a_pc), .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill));

    imm_decode_stage #(.XLEN(64), .RV64_OPS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_ov), .out_ready(out_ready),
        .out_instr(b_ins), .out_pc(b_pc), .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill));

    imm_decode_stage #(.XLEN(64), .RV64_OPS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_ir),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_ov), .out_ready(out_ready),
        .out_instr(c_ins), .out_pc(c_pc), .out_imm(c_imm), .out_fmt(c_fmt), .out_illegal(c_ill));

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[3][$];
    exp_t last[3];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference decode: immediate as a signed integer value, then truncated to XLEN.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                   input int xlen, input bit rv64);
        exp_t   e;
        longint v;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        if (ins[1:0] != 2'b11) e.ill = 1'b1;
        else begin
            case (ins[6:0])
                7'h03, 7'h0F, 7'h13, 7'h67: begin e.fmt = 1; v = $signed(ins[31:20]); end
                7'h23: begin e.fmt = 2; v = $signed({ins[31:25], ins[11:7]}); end
                7'h63: begin e.fmt = 3; v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
                7'h6F: begin e.fmt = 5; v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
                7'h37, 7'h17: begin e.fmt = 4; v = $signed({ins[31:12], 12'h000}); end
                7'h73: begin
                    if (ins[14]) begin e.fmt = 6; v = longint'(ins[19:15]); end
                    else begin e.fmt = 1; v = $signed(ins[31:20]); end
                end
                7'h33: e.fmt = 0;
                7'h1B: begin
                    if (rv64 && xlen == 64) begin e.fmt = 1; v = $signed(ins[31:20]); end
                    else e.ill = 1'b1;
                end
                default: e.ill = 1'b1;
            endcase
        end
        e.instr = ins;
        e.imm   = v;
        e.pc    = pc;
        if (xlen == 32) begin
            e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
            e.pc  = e.pc & 64'h0000_0000_FFFF_FFFF;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Occupancy model: out_valid <=> queue non-empty, in_ready <=> fewer than 2 held.
    task automatic check_dut(input int id, input int xlen, input bit rv64,
                             input logic ov, input logic ir, input logic [31:0] oi,
                             input logic [63:0] opc, input logic [63:0] oimm,
                             input logic [2:0] ofmt, input logic oill);
        exp_t e;
        int   sz;
        if (!rst_n) begin
            q[id].delete();
            last[id] = '{instr: 0, pc: 0, imm: 0, fmt: 0, ill: 0};
            return;
        end
        sz = q[id].size();
        chk("out_valid", id, 64'(ov), 64'(sz != 0));
        chk("in_ready", id, 64'(ir), 64'(sz < 2));
        e = (sz != 0) ? q[id][0] : last[id];
        chk("out_instr", id, 64'(oi), 64'(e.instr));
        chk("out_pc", id, opc, e.pc);
        chk("out_imm", id, oimm, e.imm);
        chk("out_fmt", id, 64'(ofmt), 64'(e.fmt));
        chk("out_illegal", id, 64'(oill), 64'(e.ill));
        last[id] = e;
        if (sz != 0 && out_ready) void'(q[id].pop_front());
        if (flush) q[id].delete();
        else if (in_valid && sz < 2) q[id].push_back(model(in_instr, in_pc, xlen, rv64));
    endtask

    always @(negedge clk) begin
        check_dut(0, 32, 1'b0, a_ov, a_ir, a_ins, {32'h0, a_pc}, {32'h0, a_imm}, a_fmt, a_ill);
        check_dut(1, 64, 1'b1, b_ov, b_ir, b_ins, b_pc, b_imm, b_fmt, b_ill);
        check_dut(2, 64, 1'b0, c_ov, c_ir, c_ins, c_pc, c_imm, c_fmt, c_ill);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = {$urandom, $urandom};
        step();
    endtask

    logic [31:0] dir[10] = '{32'hFFF00093, 32'hFE112E23, 32'hFFDFF06F, 32'h12345037,
                             32'h30529073, 32'h3050D073, 32'h800000B7, 32'hFFF0809B,
                             32'h00000000, 32'h0000007F};
    logic [6:0]  ops[12] = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h23, 7'h63,
                             7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h1B};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();

        // directed stream, back-to-back with out_ready high
        for (int i = 0; i < 10; i++) present(dir[i]);
        in_valid = 1'b0;
        step(); step();

        // backpressure: A, B fill both entries; C is refused until drained
        out_ready = 1'b0;
        present(32'hFFF00093);
        present(32'hFE112E23);
        present(32'h12345037);
        present(32'h12345037);
        out_ready = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        step(); step();

        // flush while FULL with a new instruction presented
        out_ready = 1'b0;
        present(32'hFFDFF06F);
        present(32'h3050D073);
        in_instr = 32'h800000B7;
        flush    = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        // reset while FULL, then illegal encodings
        out_ready = 1'b0;
        present(32'hFFF0809B);
        present(32'h30529073);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        present(32'h00000000);
        present(32'h0000007F);
        in_valid = 1'b0;
        step(); step();

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst_n     = ($urandom_range(0, 300) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        step(); step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered decode-stage block that extracts and sign-extends the immediate from a RISC-V instruction.
- Classifies the instruction format and flags illegal encodings.
- Sits between fetch and the register-read/execute stage.
- Generalises the combinational immediate extender:
  - parametrised XLEN (32/64);
  - adds CSR zimm and RV64 OP-IMM-32 support;
  - adds a valid/ready handshake with a 2-entry skid buffer and a pipeline flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (elaboration error otherwise)
RV64_OPS, 0, when 1 and XLEN==64, opcode 0011011 (OP-IMM-32) decodes as I-type; otherwise it is illegal

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  drop all held instructions; synchronous
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept; registered
in_instr  input  32  raw instruction
in_pc  input  XLEN  instruction address
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts
out_instr  output  32  instruction, passed through
out_pc  output  XLEN  pc, passed through
out_imm  output  XLEN  extended immediate
out_fmt  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z
out_illegal  output  1  unknown opcode, or instr[1:0]!=2'b11

Behaviour:
- **Decode (combinational on in_instr, captured on accept):**
  - I (fmt 1): LOAD 0000011, MISC_MEM 0001111, OP_IMM 0010011, JALR 1100111. imm = sext(instr[31:20]).
  - S (fmt 2): STORE 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B (fmt 3): BRANCH 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J (fmt 5): JAL 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U (fmt 4): LUI 0110111, AUIPC 0010111. imm = sext({instr[31:12], 12'b0}); bit 31 replicates into bits 63:32 when XLEN=64.
  - SYSTEM 1110011:
    - funct3[2]=1 → fmt 6, imm = zext(instr[19:15]).
    - otherwise fmt 1, imm = sext(instr[31:20]).
  - OP 0110011 → fmt 0, imm = 0.
  - RV64_OPS opcode 0011011 → fmt 1, as I-type.
  - Anything else, or instr[1:0]!=11 → out_illegal=1, fmt 0, imm = 0.
- **Handshake:**
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
  - Payload (instr, pc, imm, fmt, illegal) holds stable while out_valid && !out_ready.
- **Storage:** main register plus one skid register.
  - Latency: accepted instruction visible at out_* the cycle after accept.
  - Throughput: 1 per cycle while out_ready=1.
- **States (by occupancy):**
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept && emit → ONE, main loaded with the new entry.
    - Emit only → EMPTY.
    - Accept only → FULL, new entry to skid.
  - FULL: out_valid=1, in_ready=0.
    - Emit → ONE, skid moves to main.
    - No accept possible in FULL.
- **Ordering:** strict FIFO; skid content is never emitted ahead of main.
- **flush:**
  - Next state is EMPTY: out_valid=0, in_ready=1 next cycle.
  - Any same-cycle accept is discarded.
  - Same-cycle emit is still a completed transfer downstream.
- **Reset (rst_n=0 at a clk edge, including mid-stream):**
  - State EMPTY; out_valid=0; in_ready=1 after the reset edge.
  - out_instr, out_pc, out_imm = 0; out_fmt=0; out_illegal=0.
  - Reset takes priority over flush.
- **No X propagation:** payload registers load only on accept or skid transfer. When out_valid=0, outputs hold their last value (0 after reset).

Test Plan:
- XLEN=32, out_ready=1, in 0xFFF00093 (addi x1,x0,-1) → next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, illegal=0.
- Stream back-to-back, out_ready=1:
  - 0xFE112E23 (sw x1,-4(x2)) → imm=0xFFFFFFFC, fmt=2.
  - 0xFFDFF06F (jal x0,-4) → imm=0xFFFFFFFC, fmt=5.
  - 0x12345037 (lui) → imm=0x12345000, fmt=4.
  - 0x30529073 (csrrw) → fmt=1, imm=0x00000305.
  - 0x3050D073 (csrrwi zimm=1) → fmt=6, imm=0x00000001.
  - in_ready stays 1 throughout; one result per cycle.
- XLEN=64, RV64_OPS=1:
  - 0x800000B7 (lui) → imm=0xFFFFFFFF80000000.
  - 0xFFF0809B (addiw -1) → imm=0xFFFFFFFFFFFFFFFF, fmt=1.
  - With RV64_OPS=0, 0xFFF0809B → illegal=1, imm=0.
- Backpressure:
  - Hold out_ready=0, present A then B → in_ready drops to 0 after B is accepted; out shows A stable.
  - Raise out_ready → A then B emitted in order, in_ready returns to 1 the cycle after A is emitted.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1; the held entries and the presented instruction never appear at the output.
- rst_n=0 for one cycle while FULL → out_valid=0, out_imm=0, out_fmt=0, in_ready=1. Illegal inputs 0x00000000 and 0x0000007F after reset → illegal=1, imm=0.
